// File: rtl/jk_pkg.sv
// Shared definitions for the JK-based universal register: mode encodings
// and the wrap-detect helper used by the counter.
package jk_pkg;

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_COUNT = 2'b10;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    // A count wraps when every bit toggles: the carry/borrow chain reaches the
    // MSB and the MSB itself is 1 (up) or 0 (down).
    function automatic logic count_wraps(input logic chain_top, input logic msb, input logic up);
        return chain_top & (up ? msb : ~msb);
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK next-state function: 00 hold, 01 clear, 10 set, 11 toggle.
module jk_cell (
    input  logic q,
    input  logic j,
    input  logic k,
    output logic q_next
);

    // JK characteristic equation
    always_comb begin
        q_next = q;
        case ({j, k})
            2'b00:   q_next = q;
            2'b01:   q_next = 1'b0;
            2'b10:   q_next = 1'b1;
            2'b11:   q_next = ~q;
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/jk_universal_reg.sv
// Multi-bit JK register with parallel load, up/down count and bidirectional
// shift, plus registered terminal-count and change flags.
module jk_universal_reg
    import jk_pkg::*;
#(
    parameter int                     WIDTH       = 8,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             up,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             changed
);

    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic             changed_r;
    logic [WIDTH-1:0] toggle_s;
    logic [WIDTH-1:0] cell_j_s;
    logic [WIDTH-1:0] cell_k_s;
    logic [WIDTH-1:0] cell_next_s;
    logic [WIDTH-1:0] q_next_s;
    logic             wrap_s;

    // Bit i toggles in COUNT when all lower bits are 1 (up) or all 0 (down).
    assign toggle_s[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_chain
        assign toggle_s[i] = toggle_s[i-1] & (up ? q_r[i-1] : ~q_r[i-1]);
    end

    // COUNT reuses the JK cells by driving j=k=toggle
    always_comb begin
        cell_j_s = j;
        cell_k_s = k;
        if (mode == MODE_COUNT) begin
            cell_j_s = toggle_s;
            cell_k_s = toggle_s;
        end else begin
            cell_j_s = j;
            cell_k_s = k;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .q      (q_r[i]),
            .j      (cell_j_s[i]),
            .k      (cell_k_s[i]),
            .q_next (cell_next_s[i])
        );
    end

    // Mode mux selecting the next register value
    always_comb begin
        q_next_s = q_r;
        case (mode)
            MODE_JK:    q_next_s = cell_next_s;
            MODE_LOAD:  q_next_s = d;
            MODE_COUNT: q_next_s = cell_next_s;
            MODE_SHIFT: begin
                if (up) begin
                    q_next_s = {q_r[WIDTH-2:0], ser_in};
                end else begin
                    q_next_s = {ser_in, q_r[WIDTH-1:1]};
                end
            end
            default:    q_next_s = q_r;
        endcase
    end

    assign wrap_s = (mode == MODE_COUNT) && count_wraps(toggle_s[WIDTH-1], q_r[WIDTH-1], up);

    // State and flag registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r       <= RESET_VALUE;
            tc_r      <= 1'b0;
            changed_r <= 1'b0;
        end else if (en) begin
            q_r       <= q_next_s;
            tc_r      <= wrap_s;
            changed_r <= (q_next_s != q_r);
        end else begin
            q_r       <= q_r;
            tc_r      <= 1'b0;
            changed_r <= 1'b0;
        end
    end

    assign q       = q_r;
    assign tc      = tc_r;
    assign changed = changed_r;

endmodule

// File: tb/tb_jk_universal_reg.sv
// Self-checking bench for jk_universal_reg: directed scenarios followed by
// randomized traffic, all checked against an arithmetic reference model.
module tb_jk_universal_reg;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j, k, d;
    logic         up, ser_in;
    logic [W-1:0] q;
    logic         tc, changed;

    int checks = 0;
    int errors = 0;

    int m_q;
    int m_tc;
    int m_ch;

    always #5 clk = ~clk;

    jk_universal_reg #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .j       (j),
        .k       (k),
        .d       (d),
        .up      (up),
        .ser_in  (ser_in),
        .q       (q),
        .tc      (tc),
        .changed (changed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_q"}, {24'h0, q}, m_q);
        chk({tag, "_tc"}, {31'h0, tc}, m_tc);
        chk({tag, "_changed"}, {31'h0, changed}, m_ch);
    endtask

    // Apply one set of inputs across a rising edge, advance the model, compare.
    task automatic cycle(input string tag, input bit e, input int m, input int jj,
                         input int kk, input int dd, input bit u, input bit s);
        int nq;
        int ntc;
        en = e; mode = m[1:0]; j = jj[W-1:0]; k = kk[W-1:0]; d = dd[W-1:0];
        up = u; ser_in = s;
        nq  = m_q;
        ntc = 0;
        if (e) begin
            case (m)
                0: nq = (((m_q | (jj & ~kk)) & ~(~jj & kk)) ^ (jj & kk)) & MASK;
                1: nq = dd & MASK;
                2: begin
                    if (u) begin
                        ntc = (m_q == MASK);
                        nq  = (m_q + 1) % (MASK + 1);
                    end else begin
                        ntc = (m_q == 0);
                        nq  = (m_q + MASK) % (MASK + 1);
                    end
                end
                default: begin
                    if (u) nq = ((m_q * 2) + s) & MASK;
                    else   nq = (m_q / 2) + (s ? (1 << (W - 1)) : 0);
                end
            endcase
        end
        m_ch = (e && nq != m_q) ? 1 : 0;
        m_tc = e ? ntc : 0;
        m_q  = nq;
        @(posedge clk);
        #1;
        chk_model(tag);
    endtask

    // Assert reset mid-cycle, check immediate clearing, release at the next negedge.
    task automatic mid_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        m_q = 0; m_tc = 0; m_ch = 0;
        chk_model(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; j = '0; k = '0; d = '0;
        up = 1'b0; ser_in = 1'b0;
        m_q = 0; m_tc = 0; m_ch = 0;
        #12;
        chk_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        cycle("ld5a", 1, 1, 0, 0, 'h5A, 0, 0);
        chk("ld5a_direct", {24'h0, q}, 32'h5A);
        mid_reset("rst_mid");
        cycle("ldff", 1, 1, 0, 0, 'hFF, 0, 0);
        cycle("wrap_pre_rst", 1, 2, 0, 0, 0, 1, 0);
        chk("wrap_pre_rst_tc", {31'h0, tc}, 32'h1);
        mid_reset("rst_tc");

        cycle("ldf0", 1, 1, 0, 0, 'hF0, 0, 0);
        cycle("jk1", 1, 0, 'h0C, 'h30, 0, 0, 0);
        chk("jk1_direct", {24'h0, q}, 32'hCC);
        cycle("jk2", 1, 0, 'hFF, 'hFF, 0, 0, 0);
        chk("jk2_direct", {24'h0, q}, 32'h33);

        cycle("lda5", 1, 1, 0, 0, 'hA5, 0, 0);
        cycle("lda5_again", 1, 1, 0, 0, 'hA5, 0, 0);
        chk("lda5_again_changed", {31'h0, changed}, 32'h0);
        for (int i = 0; i < 3; i++) cycle("hold", 0, 2, 'hFF, 'hFF, 0, 1, 1);
        chk("hold_direct", {24'h0, q}, 32'hA5);

        cycle("ldfe", 1, 1, 0, 0, 'hFE, 0, 0);
        cycle("cnt_ff", 1, 2, 0, 0, 0, 1, 0);
        cycle("cnt_00", 1, 2, 0, 0, 0, 1, 0);
        chk("cnt_00_tc", {31'h0, tc}, 32'h1);
        cycle("cnt_01", 1, 2, 0, 0, 0, 1, 0);
        cycle("ld00", 1, 1, 0, 0, 0, 0, 0);
        cycle("cnt_dn", 1, 2, 0, 0, 0, 0, 0);
        chk("cnt_dn_direct", {24'h0, q}, 32'hFF);
        chk("cnt_dn_tc", {31'h0, tc}, 32'h1);

        cycle("ld81", 1, 1, 0, 0, 'h81, 0, 0);
        cycle("shl", 1, 3, 0, 0, 0, 1, 0);
        chk("shl_direct", {24'h0, q}, 32'h02);
        cycle("shr", 1, 3, 0, 0, 0, 0, 1);
        chk("shr_direct", {24'h0, q}, 32'h81);

        cycle("mix_ld", 1, 1, 0, 0, 'h10, 0, 0);
        cycle("mix_cnt", 1, 2, 0, 0, 0, 1, 0);
        cycle("mix_sh", 1, 3, 0, 0, 0, 1, 1);
        cycle("mix_jk", 1, 0, 'hFF, 'hFF, 0, 0, 0);
        chk("mix_direct", {24'h0, q}, 32'hDC);

        for (int n = 0; n < 600; n++) begin
            int r;
            int dd;
            r  = $urandom_range(0, 3);
            dd = (r == 0) ? 'hFF : ((r == 1) ? 0 : int'($urandom));
            cycle("rnd", ($urandom_range(0, 9) != 0), $urandom_range(0, 3),
                  $urandom, $urandom, dd, $urandom_range(0, 1), $urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) mid_reset("rnd_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
